booth_mul_iter: RTL and testbench
=================================

# booth_mul_iter

Parametrised iterative radix-4 Booth multiplier for the execute stage, successor to the single-shot 32-bit multiplier. It retires a configurable number of Booth groups per cycle, which trades latency against area. It latches its operands on acceptance, supports signed and unsigned products, can be aborted by a pipeline flush, and optionally accumulates into a 2*WIDTH value (MADD/MSUB).

## Interface
- WIDTH, 32: operand width; even, 8..64.
- GROUPS, 4: Booth groups reduced per CALC cycle; 1..(WIDTH/2+1).
- Derived NGRP = WIDTH/2+1; ITER = ceil(NGRP/GROUPS).

- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE with flush=0.
- flag_unsigned  in  1  1 = zero-extend both operands, 0 = sign-extend; sampled at acceptance.
- operand1  in  WIDTH  multiplicand; sampled at acceptance.
- operand2  in  WIDTH  multiplier; sampled at acceptance.
- flush  in  1  abort the current operation; synchronous.
- acc_en  in  1  (MUL_ACCUM_EN only) accumulate enable; sampled at acceptance.
- acc_sub  in  1  (MUL_ACCUM_EN only) 1 = subtract the product from acc_in.
- acc_in  in  2*WIDTH  (MUL_ACCUM_EN only) accumulator operand; sampled at acceptance.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when result updates.
- result  out  2*WIDTH  product or accumulated value; holds until the next done.

## Operation
- Extension: both operands are extended to WIDTH+2 bits (sign or zero per flag_unsigned). The multiplier gets an implicit 0 appended below bit 0, then is recoded into NGRP overlapping 3-bit groups.
- Group recoding: each group i maps to {0, +M, +2M, -M, -2M} << 2i. M is the extended multiplicand held in 2*WIDTH bits. Negation is two's complement (invert plus one), folded into the same adder.
- All arithmetic is modulo 2^(2*WIDTH); the result is the exact 2*WIDTH-bit product for both signednesses. No final correction term is used.
- States: IDLE, CALC, FINISH.
  - IDLE -> CALC on start & !flush. Operands are latched, the accumulator is cleared, and group counter gidx = 0.
  - CALC: each edge adds the partial products of groups gidx..gidx+GROUPS-1 (groups >= NGRP contribute 0), then gidx += GROUPS. After ITER CALC edges -> FINISH.
  - FINISH: result <= acc (or the accumulate form below), done <= 1 -> IDLE.
- flush in CALC or FINISH -> IDLE at the next edge; result is unchanged and no done pulse is produced.
- start while busy: ignored, not queued.
- start and flush in the same cycle in IDLE: flush wins, nothing is accepted.

## Timing
- Reset (reset=0 at an edge): state IDLE, busy 0, done 0, result 0, internal accumulator 0.
- Reset dominates flush and start. Reset mid-operation discards the operation without a done pulse.
- Latency: accepting edge E0; done is high in the cycle after edge E0+ITER+1.
  - WIDTH=32, GROUPS=4: ITER=5, done after 6 edges.
  - GROUPS=17: ITER=1, done after 2 edges.
- busy rises after E0 and falls after the FINISH edge, in the same cycle done is high. Back-to-back start in that cycle is accepted.
- Maximum throughput: one operation per ITER+2 cycles.
- Operand inputs may change freely after E0.

## Configuration
- MUL_ACCUM_EN defined:
  - acc_en, acc_sub and acc_in ports exist.
  - In FINISH: result = acc_in + P when acc_en=1 and acc_sub=0; result = acc_in - P when acc_en=1 and acc_sub=1; result = P when acc_en=0. All modulo 2^(2*WIDTH).
  - Accumulation adds no cycles.
- MUL_ACCUM_EN undefined: these ports and the extra adder are absent, and result = P always.

## Test plan
- WIDTH=32, GROUPS=4, signed, 0xFFFFFFFF * 0xFFFFFFFF -> result 0x0000000000000001; done exactly 6 edges after acceptance, busy high for 6 cycles.
- Unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE00000001. Signed 0x80000000 * 0x80000000 -> 0x4000000000000000. Signed 0x80000000 * 0x00000001 -> 0xFFFFFFFF80000000.
- Start 7*9; pulse flush at the 3rd CALC cycle -> no done, result keeps its prior value, busy low next cycle. A new start 3*4 then yields 0x0C.
- Start held high continuously with random operands, WIDTH=16/GROUPS=1 and WIDTH=64/GROUPS=33 -> one done per ITER+2 cycles. Every result matches the reference model, and operand changes after acceptance have no effect.
- Drive reset=0 mid-CALC -> busy 0, done 0, result 0 next cycle. Start in the same cycle as flush in IDLE -> not accepted.
- MUL_ACCUM_EN: acc_in=0x10, acc_en=1, acc_sub=1, 3*5 signed -> 0x0000000000000001. acc_sub=0, unsigned 0xFFFFFFFF*2 with acc_in=2 -> 0x0000000200000000.

Source files
------------

// File: rtl/booth_mul_iter_if.sv
// booth_mul_iter_if
//   Request/result bundle between the execute stage and booth_mul_iter.
//
//   Handshake: start is a request without a ready line. The multiplier
//   accepts it at a clock edge where busy=0 and flush=0. A request seen
//   while busy=1 is dropped, not queued. done is a one-cycle pulse in the
//   cycle that result takes its new value. result then holds until the
//   next done.
//
//   Signals (master = requester, slave = multiplier):
//     start, flag_unsigned, operand1, operand2, flush   master -> slave
//     acc_en, acc_sub, acc_in   master -> slave, only with MUL_ACCUM_EN
//     busy, done, result                                 slave -> master
//
//   Optional feature macro: MUL_ACCUM_EN (adds the accumulate signals).
interface booth_mul_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 flag_unsigned;
  logic [WIDTH-1:0]     operand1;
  logic [WIDTH-1:0]     operand2;
  logic                 flush;
`ifdef MUL_ACCUM_EN
  logic                 acc_en;
  logic                 acc_sub;
  logic [2*WIDTH-1:0]   acc_in;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

`ifdef MUL_ACCUM_EN
  modport master (
    output start, flag_unsigned, operand1, operand2, flush,
    output acc_en, acc_sub, acc_in,
    input  busy, done, result
  );
  modport slave (
    input  start, flag_unsigned, operand1, operand2, flush,
    input  acc_en, acc_sub, acc_in,
    output busy, done, result
  );
`else
  modport master (
    output start, flag_unsigned, operand1, operand2, flush,
    input  busy, done, result
  );
  modport slave (
    input  start, flag_unsigned, operand1, operand2, flush,
    output busy, done, result
  );
`endif
endinterface

// File: rtl/booth_mul_iter.sv
// booth_mul_iter
//   Iterative radix-4 Booth multiplier. Each CALC cycle retires GROUPS
//   Booth groups, so a multiply takes ITER = ceil((WIDTH/2+1)/GROUPS) CALC
//   cycles plus one FINISH cycle. It supports signed and unsigned operands
//   and can be aborted by flush.
//
//   Parameters:
//     WIDTH   operand width, even, 8..64
//     GROUPS  Booth groups reduced per CALC cycle, 1..WIDTH/2+1
//
//   Ports:
//     clock        clock
//     reset        synchronous, active-low reset
//     bus          booth_mul_iter_if slave modport. It carries the
//                  request, operands, flush, busy, done and result.
//     dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 FINISH)
//
//   Optional feature macro: MUL_ACCUM_EN. When it is defined, FINISH
//   returns acc_in + P or acc_in - P instead of P, modulo 2^(2*WIDTH).
module booth_mul_iter #(
  parameter int WIDTH  = 32,
  parameter int GROUPS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  booth_mul_iter_if.slave        bus,
  output logic [1:0]             dbg_state_o
);

  localparam int NGRP = WIDTH / 2 + 1;
  localparam int ITER = (NGRP + GROUPS - 1) / GROUPS;
  localparam int PW   = 2 * WIDTH;
  localparam int XW   = WIDTH + 2;
  // The multiplier register spans every group slot of every iteration.
  // Slots beyond NGRP then read only sign-extension bits. Those recode to
  // 000 or 111, so they add nothing and need no explicit masking.
  localparam int MPW  = 2 * GROUPS * ITER + 1;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [MPW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    result_q, result_d;
  logic             done_q, done_d;
`ifdef MUL_ACCUM_EN
  logic             acc_en_q, acc_en_d;
  logic             acc_sub_q, acc_sub_d;
  logic [PW-1:0]    acc_in_q, acc_in_d;
`endif

  // Operands extended to WIDTH+2 bits. The extension bit is the operand's
  // top bit for signed operands and 0 for unsigned ones.
  logic [XW-1:0]    x_ext, y_ext;
  logic [XW:0]      y_sh;
  logic [PW-1:0]    mcand_init;
  logic [MPW-1:0]   mplier_init;

  assign x_ext       = {{2{~bus.flag_unsigned & bus.operand1[WIDTH-1]}}, bus.operand1};
  assign y_ext       = {{2{~bus.flag_unsigned & bus.operand2[WIDTH-1]}}, bus.operand2};
  assign y_sh        = {y_ext, 1'b0};
  assign mcand_init  = PW'($signed(x_ext));
  assign mplier_init = MPW'($signed(y_sh));

  // Sum of this cycle's GROUPS partial products. The multiplicand and
  // multiplier registers shift by 2*GROUPS every CALC cycle, so group g
  // here is always at bit offset 2*g relative to the current window.
  logic [PW-1:0]    pp_sum;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    term;
  logic [2:0]       grp;
  logic             neg;

  always_comb begin
    pp_sum = '0;
    mag    = '0;
    term   = '0;
    grp    = '0;
    neg    = 1'b0;
    for (int g = 0; g < GROUPS; g++) begin
      grp = mplier_q[2*g +: 3];
      mag = '0;
      neg = 1'b0;
      case (grp)
        3'b001, 3'b010: mag = mcand_q;
        3'b011:         mag = mcand_q << 1;
        3'b100: begin
          mag = mcand_q << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = mcand_q;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      term = mag << (2 * g);
      // Negation is done as invert plus a carry-in of the same adder.
      pp_sum = pp_sum + (neg ? ~term : term) + {{(PW-1){1'b0}}, neg};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef MUL_ACCUM_EN
    acc_en_d  = acc_en_q;
    acc_sub_d = acc_sub_q;
    acc_in_d  = acc_in_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          mcand_d   = mcand_init;
          mplier_d  = mplier_init;
          acc_d     = '0;
          cnt_d     = '0;
`ifdef MUL_ACCUM_EN
          acc_en_d  = bus.acc_en;
          acc_sub_d = bus.acc_sub;
          acc_in_d  = bus.acc_in;
`endif
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_q + pp_sum;
          mcand_d  = mcand_q << (2 * GROUPS);
          mplier_d = MPW'($signed(mplier_q) >>> (2 * GROUPS));
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
`ifdef MUL_ACCUM_EN
          if (acc_en_q) begin
            result_d = acc_sub_q ? (acc_in_q - acc_q) : (acc_in_q + acc_q);
          end else begin
            result_d = acc_q;
          end
`else
          result_d = acc_q;
`endif
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifdef MUL_ACCUM_EN
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
      acc_in_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
`ifdef MUL_ACCUM_EN
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
      acc_in_q  <= acc_in_d;
`endif
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// tb_booth_mul_iter
//   Bench for booth_mul_iter. Three instances share one stimulus set:
//   WIDTH=32/GROUPS=4, WIDTH=16/GROUPS=1 and WIDTH=64/GROUPS=33.
//   Expected products come from plain wide multiplication of the extended
//   operands.
module tb_booth_mul_iter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        uns   = 1'b0;
  logic [63:0] op1   = '0;
  logic [63:0] op2   = '0;
`ifdef MUL_ACCUM_EN
  logic         acc_en  = 1'b0;
  logic         acc_sub = 1'b0;
  logic [127:0] acc_in  = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  booth_mul_iter_if #(.WIDTH(32)) if32();
  booth_mul_iter_if #(.WIDTH(16)) if16();
  booth_mul_iter_if #(.WIDTH(64)) if64();

  assign if32.start = start;  assign if32.flush = flush;  assign if32.flag_unsigned = uns;
  assign if16.start = start;  assign if16.flush = flush;  assign if16.flag_unsigned = uns;
  assign if64.start = start;  assign if64.flush = flush;  assign if64.flag_unsigned = uns;
  assign if32.operand1 = op1[31:0];  assign if32.operand2 = op2[31:0];
  assign if16.operand1 = op1[15:0];  assign if16.operand2 = op2[15:0];
  assign if64.operand1 = op1;        assign if64.operand2 = op2;
`ifdef MUL_ACCUM_EN
  assign if32.acc_en = acc_en;  assign if32.acc_sub = acc_sub;  assign if32.acc_in = acc_in[63:0];
  assign if16.acc_en = acc_en;  assign if16.acc_sub = acc_sub;  assign if16.acc_in = acc_in[31:0];
  assign if64.acc_en = acc_en;  assign if64.acc_sub = acc_sub;  assign if64.acc_in = acc_in;
`endif

  logic [1:0] st32, st16, st64;

  booth_mul_iter #(.WIDTH(32), .GROUPS(4))  u32 (.clock(clock), .reset(reset), .bus(if32), .dbg_state_o(st32));
  booth_mul_iter #(.WIDTH(16), .GROUPS(1))  u16 (.clock(clock), .reset(reset), .bus(if16), .dbg_state_o(st16));
  booth_mul_iter #(.WIDTH(64), .GROUPS(33)) u64 (.clock(clock), .reset(reset), .bus(if64), .dbg_state_o(st64));

  logic         done_v [3];
  logic         busy_v [3];
  logic [127:0] res_v  [3];
  assign done_v[0] = if32.done;  assign busy_v[0] = if32.busy;  assign res_v[0] = {64'b0, if32.result};
  assign done_v[1] = if16.done;  assign busy_v[1] = if16.busy;  assign res_v[1] = {96'b0, if16.result};
  assign done_v[2] = if64.done;  assign busy_v[2] = if64.busy;  assign res_v[2] = if64.result;

  // ---------------- reference model ----------------
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input int w, input logic u);
    logic [127:0] ea, eb, p;
    ea = '0;
    eb = '0;
    for (int i = 0; i < w; i++) begin
      ea[i] = a[i];
      eb[i] = b[i];
    end
    for (int i = w; i < 128; i++) begin
      ea[i] = u ? 1'b0 : a[w-1];
      eb[i] = u ? 1'b0 : b[w-1];
    end
    p = ea * eb;
    for (int i = 2 * w; i < 128; i++) p[i] = 1'b0;
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issue one operation on the 32-bit instance and wait for done.
  // Operands are scrambled right after acceptance.
  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic u,
                          output logic [127:0] res, output int lat, output int busy_cyc);
    op1 = {32'h0, a};
    op2 = {32'h0, b};
    uns = u;
    start = 1'b1;
    tick();
    start = 1'b0;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    uns = 1'($urandom_range(0, 1));
    lat = 0;
    busy_cyc = 0;
    while (!done_v[0] && lat < 50) begin
      if (busy_v[0]) busy_cyc++;
      tick();
      lat++;
    end
    res = res_v[0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (busy_v[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_v[k]); end
      n_vec++;
      if (done_v[k] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_v[k]); end
      n_vec++;
      if (res_v[k] !== 128'h0) begin n_err++; $display("FAIL reset_result[%0d]: got %h expected 0", k, res_v[k]); end
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0]  ta [4];
    logic [31:0]  tb [4];
    logic         tu [4];
    logic [127:0] te [4];
    logic [127:0] res;
    int lat, bc;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'hFFFFFFFF; tu[0] = 1'b0; te[0] = 128'h0000000000000001;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF; tu[1] = 1'b1; te[1] = 128'hFFFFFFFE00000001;
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; tu[2] = 1'b0; te[2] = 128'h4000000000000000;
    ta[3] = 32'h80000000; tb[3] = 32'h00000001; tu[3] = 1'b0; te[3] = 128'hFFFFFFFF80000000;
    for (int i = 0; i < 4; i++) begin
      run_op32(ta[i], tb[i], tu[i], res, lat, bc);
      n_vec++;
      if (res !== te[i]) begin n_err++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, te[i]); end
      n_vec++;
      if (lat !== 6) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d expected 6", i, lat); end
      n_vec++;
      if (bc !== 6) begin n_err++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 6", i, bc); end
      n_vec++;
      if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL directed_busy_at_done[%0d]: got %b expected 0", i, busy_v[0]); end
      tick();
      n_vec++;
      if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL directed_done_pulse[%0d]: got %b expected 0", i, done_v[0]); end
    end
  endtask

  task automatic test_random32();
    logic [31:0]  a, b;
    logic         u;
    logic [127:0] res, ex;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      u = 1'($urandom_range(0, 1));
      ex = ref_mul({32'h0, a}, {32'h0, b}, 32, u);
      run_op32(a, b, u, res, lat, bc);
      n_vec++;
      if (res !== ex) begin n_err++; $display("FAIL random32[%0d]: got %h expected %h (a=%h b=%h u=%b)", i, res, ex, a, b, u); end
    end
    idle(2);
  endtask

  task automatic test_flush();
    logic [127:0] res;
    int lat, bc, ndone;
    run_op32(32'd5, 32'd6, 1'b0, res, lat, bc);
    n_vec++;
    if (res !== 128'd30) begin n_err++; $display("FAIL flush_prior: got %h expected 1e", res); end
    tick();
    op1 = 64'd7;
    op2 = 64'd9;
    uns = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy_v[0]); end
    n_vec++;
    if (res_v[0] !== 128'd30) begin n_err++; $display("FAIL flush_result_kept: got %h expected 1e", res_v[0]); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) ndone++;
      tick();
    end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d pulses expected 0", ndone); end
    run_op32(32'd3, 32'd4, 1'b0, res, lat, bc);
    n_vec++;
    if (res !== 128'h0C) begin n_err++; $display("FAIL flush_next_op: got %h expected c", res); end
    n_vec++;
    if (lat !== 6) begin n_err++; $display("FAIL flush_next_latency: got %0d expected 6", lat); end
    idle(2);
  endtask

  task automatic test_start_flush_idle();
    int ndone;
    op1 = 64'd9;
    op2 = 64'd9;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    n_vec++;
    if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL start_flush_busy: got %b expected 0", busy_v[0]); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) ndone++;
      tick();
    end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL start_flush_no_done: got %0d pulses expected 0", ndone); end
    n_vec++;
    if (res_v[0] !== 128'h0C) begin n_err++; $display("FAIL start_flush_result: got %h expected c", res_v[0]); end
  endtask

  task automatic test_ignore_busy();
    int n, ndone;
    op1 = 64'd11;
    op2 = 64'd13;
    uns = 1'b0;
    start = 1'b1;
    tick();
    op1 = 64'd100;
    op2 = 64'd100;
    tick();
    tick();
    tick();
    start = 1'b0;
    n = 0;
    while (!done_v[0] && n < 50) begin tick(); n++; end
    n_vec++;
    if (done_v[0] !== 1'b1) begin n_err++; $display("FAIL ignore_busy_timeout: no done within 50 cycles"); end
    n_vec++;
    if (res_v[0] !== 128'd143) begin n_err++; $display("FAIL ignore_busy_result: got %h expected 8f", res_v[0]); end
    tick();
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) ndone++;
      tick();
    end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL ignore_busy_queued: got %0d extra pulses expected 0", ndone); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    op1 = 64'd7;
    op2 = 64'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++;
    if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %b expected 0", busy_v[0]); end
    n_vec++;
    if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_mid_done: got %b expected 0", done_v[0]); end
    n_vec++;
    if (res_v[0] !== 128'h0) begin n_err++; $display("FAIL reset_mid_result: got %h expected 0", res_v[0]); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) ndone++;
      tick();
    end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", ndone); end
  endtask

  // start held high with fresh random operands every cycle; the selected
  // instance must finish one operation every p = ITER+2 cycles.
  task automatic test_back_to_back(input int idx, input int w, input int p, input int nops);
    logic [127:0] ex;
    logic         exp_done;
    idle(20);
    exp_q.delete();
    for (int e = 0; e < nops * p; e++) begin
      op1 = {$urandom, $urandom};
      op2 = {$urandom, $urandom};
      uns = 1'($urandom_range(0, 1));
      start = 1'b1;
      if (e % p == 0) exp_q.push_back(ref_mul(op1, op2, w, uns));
      tick();
      exp_done = (e % p == p - 1);
      n_vec++;
      if (done_v[idx] !== exp_done) begin
        n_err++;
        $display("FAIL b2b_done[w%0d e%0d]: got %b expected %b", w, e, done_v[idx], exp_done);
      end
      if (done_v[idx] === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra[w%0d e%0d]: got done expected none", w, e);
        end else begin
          ex = exp_q.pop_front();
          if (res_v[idx] !== ex) begin
            n_err++;
            $display("FAIL b2b_result[w%0d e%0d]: got %h expected %h", w, e, res_v[idx], ex);
          end
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing[w%0d]: got %0d pending expected 0", w, exp_q.size()); end
    idle(20);
  endtask

`ifdef MUL_ACCUM_EN
  task automatic test_accum();
    logic [127:0] res;
    int lat, bc;
    acc_in = 128'h10;
    acc_en = 1'b1;
    acc_sub = 1'b1;
    run_op32(32'd3, 32'd5, 1'b0, res, lat, bc);
    n_vec++;
    if (res !== 128'h1) begin n_err++; $display("FAIL accum_sub: got %h expected 1", res); end
    n_vec++;
    if (lat !== 6) begin n_err++; $display("FAIL accum_latency: got %0d expected 6", lat); end
    tick();
    acc_in = 128'h2;
    acc_sub = 1'b0;
    run_op32(32'hFFFFFFFF, 32'd2, 1'b1, res, lat, bc);
    n_vec++;
    if (res !== 128'h0000000200000000) begin n_err++; $display("FAIL accum_add: got %h expected 200000000", res); end
    acc_en = 1'b0;
    acc_sub = 1'b0;
    acc_in = '0;
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random32();
    test_flush();
    test_start_flush_idle();
    test_ignore_busy();
    test_reset_mid();
`ifdef MUL_ACCUM_EN
    test_accum();
`endif
    test_back_to_back(1, 16, 11, 6);
    test_back_to_back(2, 64, 3, 12);
    test_back_to_back(0, 32, 7, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
